// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package serial_compare_ctrl_pkg;

    // Sequencer states; the unused encoding 2'd3 recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Slice counter width: $clog2(nslice), never narrower than one bit.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/two_bit_comparator.sv
// One 2-bit magnitude slice with chained equal/greater inputs from the
// more significant slices.
module two_bit_comparator (
    input  logic       preEQ,
    input  logic       preGT,
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       EQ,
    output logic       GT
);

    // Still equal only if all higher slices were equal and this one is too;
    // greater is decided by the first slice that differs.
    always_comb begin
        EQ = preEQ & (A == B);
        GT = preGT | (preEQ & (A > B));
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencer that runs one two_bit_comparator slice MSB-first over two
// WIDTH-bit operands, 2 bits per cycle, with a start/done handshake.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("serial_compare_ctrl: WIDTH must be even and >= 4");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_finish;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_pre_eq;
    logic             r_pre_gt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       w_sl_a;
    logic [1:0]       w_sl_b;
    logic             w_eq;
    logic             w_gt;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    // Select the operand slice addressed by the counter.
    always_comb begin
        w_sl_a = r_a[{r_idx, 1'b0} +: 2];
        w_sl_b = r_b[{r_idx, 1'b0} +: 2];
    end

    two_bit_comparator u_slice (
        .preEQ (r_pre_eq),
        .preGT (r_pre_gt),
        .A     (w_sl_a),
        .B     (w_sl_b),
        .EQ    (w_eq),
        .GT    (w_gt)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus accept/finish strobes for the datapath.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == '0 || (EARLY_EXIT != 0 && !w_eq)) begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, chained pre-registers, slice counter and registered
    // outputs; busy/done are decoded from the next state so they line up
    // with the state register without any input-to-output path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_pre_eq <= 1'b0;
            r_pre_gt <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_pre_eq <= 1'b1;
                r_pre_gt <= 1'b0;
                r_idx    <= IDX_LAST;
            end else if (r_state == S_RUN) begin
                r_pre_eq <= w_eq;
                r_pre_gt <= w_gt;
                if (r_idx != '0) begin
                    r_idx <= r_idx - IDX_W'(1);
                end
            end
            if (w_finish) begin
                r_eq <= w_eq;
                r_gt <= w_gt;
                r_lt <= ~w_eq & ~w_gt;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: two instances (EARLY_EXIT 0 and 1) with
// WIDTH=8, directed table, multi-cycle corner sequences and random pairs.
module tb_serial_compare_ctrl;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start_s [2];
    logic [W-1:0] a_s     [2];
    logic [W-1:0] b_s     [2];
    logic         busy_s  [2];
    logic         done_s  [2];
    logic         eq_s    [2];
    logic         gt_s    [2];
    logic         lt_s    [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(0)) u_dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start_s[0]),
        .a       (a_s[0]),
        .b       (b_s[0]),
        .busy    (busy_s[0]),
        .done    (done_s[0]),
        .eq      (eq_s[0]),
        .gt      (gt_s[0]),
        .lt      (lt_s[0])
    );

    serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start_s[1]),
        .a       (a_s[1]),
        .b       (b_s[1]),
        .busy    (busy_s[1]),
        .done    (done_s[1]),
        .eq      (eq_s[1]),
        .gt      (gt_s[1]),
        .lt      (lt_s[1])
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           d;
        logic         eq;
        logic         gt;
        logic         lt;
        int           lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference latency: full NSLICE without early exit; otherwise the
    // slice holding the most significant differing bit, counted from 1.
    function automatic int model_lat(input int d, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        if (d == 0 || x == '0) return W / 2;
        for (int p = W - 1; p >= 0; p--) begin
            if (x[p]) return (W - 1 - p) / 2 + 1;
        end
        return W / 2;
    endfunction

    // One full transaction on instance d, with expected results supplied.
    task automatic run_cmp(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit scramble, input string tag,
                           input logic e_eq, input logic e_gt, input logic e_lt,
                           input int e_lat);
        int k;
        int bcnt;
        start_s[d] = 1'b1;
        a_s[d]     = a;
        b_s[d]     = b;
        step();
        start_s[d] = 1'b0;
        k    = 0;
        bcnt = 0;
        while (done_s[d] !== 1'b1 && k < 40) begin
            if (busy_s[d] === 1'b1) bcnt++;
            if (scramble) begin
                a_s[d] = W'($urandom);
                b_s[d] = W'($urandom);
            end
            step();
            k++;
        end
        chk({tag, "_latency"}, d, k, e_lat);
        chk({tag, "_busy_cycles"}, d, bcnt, e_lat);
        chk({tag, "_busy_at_done"}, d, busy_s[d], 1'b0);
        chk({tag, "_eq"}, d, eq_s[d], e_eq);
        chk({tag, "_gt"}, d, gt_s[d], e_gt);
        chk({tag, "_lt"}, d, lt_s[d], e_lt);
        step();
        chk({tag, "_done_pulse"}, d, done_s[d], 1'b0);
        chk({tag, "_eq_held"}, d, eq_s[d], e_eq);
        chk({tag, "_gt_held"}, d, gt_s[d], e_gt);
    endtask

    initial begin
        int k;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            a_s[d]     = '0;
            b_s[d]     = '0;
        end

        // Directed table: {a, b, instance, eq, gt, lt, latency}
        tbl.push_back('{8'hA5, 8'hA5, 0, 1'b1, 1'b0, 1'b0, 4});
        tbl.push_back('{8'hA5, 8'hA5, 1, 1'b1, 1'b0, 1'b0, 4});
        tbl.push_back('{8'h80, 8'h7F, 1, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{8'h80, 8'h7F, 0, 1'b0, 1'b1, 1'b0, 4});
        tbl.push_back('{8'h3C, 8'h3D, 0, 1'b0, 1'b0, 1'b1, 4});
        tbl.push_back('{8'h3C, 8'h3D, 1, 1'b0, 1'b0, 1'b1, 4});
        tbl.push_back('{8'h00, 8'hC0, 1, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{8'h10, 8'h20, 1, 1'b0, 1'b0, 1'b1, 2});
        tbl.push_back('{8'h0C, 8'h08, 1, 1'b0, 1'b1, 1'b0, 3});
        tbl.push_back('{8'h0C, 8'h08, 0, 1'b0, 1'b1, 1'b0, 4});
        tbl.push_back('{8'h01, 8'h00, 1, 1'b0, 1'b1, 1'b0, 4});
        tbl.push_back('{8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 4});
        tbl.push_back('{8'hFF, 8'hFE, 0, 1'b0, 1'b1, 1'b0, 4});

        // Reset state
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, busy_s[d], 1'b0);
            chk("rst_done", d, done_s[d], 1'b0);
            chk("rst_eq", d, eq_s[d], 1'b0);
            chk("rst_gt", d, gt_s[d], 1'b0);
            chk("rst_lt", d, lt_s[d], 1'b0);
        end
        reset_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            chk("idle_busy", d, busy_s[d], 1'b0);
            chk("idle_done", d, done_s[d], 1'b0);
        end

        foreach (tbl[i]) begin
            run_cmp(tbl[i].d, tbl[i].a, tbl[i].b, 1'b0, "tbl",
                    tbl[i].eq, tbl[i].gt, tbl[i].lt, tbl[i].lat);
        end

        // Operand changes during RUN must not disturb the latched compare
        for (int d = 0; d < 2; d++) begin
            run_cmp(d, 8'h3C, 8'h3D, 1'b1, "scramble", 1'b0, 1'b0, 1'b1, 4);
        end

        // start held through RUN is ignored; restart from the DONE cycle
        start_s[0] = 1'b1;
        a_s[0]     = 8'h55;
        b_s[0]     = 8'h55;
        step();
        a_s[0] = 8'hAA;
        b_s[0] = 8'h00;
        k = 0;
        while (done_s[0] !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("hold_latency", 0, k, 4);
        chk("hold_eq", 0, eq_s[0], 1'b1);
        chk("hold_gt", 0, gt_s[0], 1'b0);
        a_s[0] = 8'h01;
        b_s[0] = 8'h00;
        step();
        start_s[0] = 1'b0;
        chk("b2b_busy", 0, busy_s[0], 1'b1);
        chk("b2b_done", 0, done_s[0], 1'b0);
        chk("b2b_eq_held", 0, eq_s[0], 1'b1);
        k = 0;
        while (done_s[0] !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("b2b_latency", 0, k, 4);
        chk("b2b_gt", 0, gt_s[0], 1'b1);
        chk("b2b_eq", 0, eq_s[0], 1'b0);
        chk("b2b_lt", 0, lt_s[0], 1'b0);
        step();

        // Asynchronous reset while idx==2 aborts both compares
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b1;
            a_s[d]     = 8'h12;
            b_s[d]     = 8'h12;
        end
        step();
        for (int d = 0; d < 2; d++) start_s[d] = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_busy", d, busy_s[d], 1'b0);
            chk("abort_done", d, done_s[d], 1'b0);
            chk("abort_eq", d, eq_s[d], 1'b0);
            chk("abort_gt", d, gt_s[d], 1'b0);
            chk("abort_lt", d, lt_s[d], 1'b0);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                chk("abort_no_done", d, done_s[d], 1'b0);
                chk("abort_no_busy", d, busy_s[d], 1'b0);
            end
        end
        for (int d = 0; d < 2; d++) begin
            run_cmp(d, 8'hFF, 8'hFF, 1'b0, "post_rst", 1'b1, 1'b0, 1'b0, 4);
        end

        // Random pairs against the arithmetic reference
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = W'($urandom);
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                    default: rb = W'($urandom);
                endcase
                run_cmp(d, ra, rb, 1'b0, "rand",
                        (ra == rb), (ra > rb), (ra < rb), model_lat(d, ra, rb));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
